sva_thread_scheduler: RTL and testbench
=======================================

// Module: sva_thread_scheduler
// PURPOSE
//  Schedules a pool of concurrent assertion threads in the SVA checker onto one shared next-state evaluator.
//  On each sample event it walks every live thread once, issues each to the evaluator over a req/ack handshake and writes back the result.
//  It then spawns one new thread from START_STATE, and reports succ/fail/lazy events and counts.
//  It sits between the gclk edge/sample logic and the generated per-property evaluator function block.
// PARAMETERS
//  MAX_THREADS  4   thread slots in the pool (>=2); SLOT_W = $clog2(MAX_THREADS)
//  STATE_W      4   width of evaluator state code
//  START_STATE  0   state code loaded into a newly spawned thread
//  EPOCH_W      8   width of epoch counter and per-thread start stamp (wraps)
//  CNT_W        16  width of saturating succ/fail counters
// PORTS
//  gclk            in   1        clock
//  grst            in   1        reset, asynchronous, active-high
//  sample_vld      in   1        1-cycle pulse: new sample epoch, start evaluation
//  busy            out  1        scheduler not IDLE
//  ev_req          out  1        evaluation request to shared evaluator
//  ev_slot         out  SLOT_W   slot index under evaluation
//  ev_state        out  STATE_W  current state of that thread
//  ev_start        out  EPOCH_W  epoch stamp at which that thread was spawned
//  ev_ack          in   1        evaluator accepts; next-state fields valid this cycle
//  ev_next_state   in   STATE_W  next state
//  ev_next_active  in   1        thread remains alive
//  ev_result       in   2        00 none, 01 succ, 10 fail, 11 lazy_succ
//  succ/fail/lazy  out  1 each   1-cycle pulse, cycle after ack carrying that result
//  done            out  1        1-cycle pulse: epoch finished
//  overrun         out  1        1-cycle pulse: sample_vld while busy (sample dropped)
//  spawn_drop      out  1        1-cycle pulse: no free slot at spawn
//  active_cnt      out  SLOT_W+1 number of valid slots
//  succ_cnt/fail_cnt out CNT_W   saturating event counters
// BEHAVIOUR
//  Reset: state IDLE; valid mask, all slot state, epoch, counters = 0; every output 0.
//  grst mid-epoch aborts immediately; ev_req drops in the same cycle (async).
//  IDLE: on sample_vld -> capture snap = valid mask, cur = 0, epoch++ (wraps) -> SCAN.
//  SCAN: lowest slot i >= cur with snap[i]=1 -> ISSUE(i); none -> SPAWN.
//  ISSUE: ev_req=1; ev_slot/ev_state/ev_start held stable until ev_ack.
//   - Ack may arrive in the same cycle as req.
//   - On ack: slot[i].state = ev_next_state; valid[i] = ev_next_active; cur = i+1 -> SCAN.
//  SPAWN: pick lowest slot with valid=0, using the current mask, so slots freed this epoch are reusable.
//   - None free: spawn_drop pulse -> DONE.
//   - Else issue START_STATE with ev_start=epoch, same handshake.
//   - On ack: valid = ev_next_active and state = ev_next_state; stamp = epoch.
//  DONE: done pulse 1 cycle -> IDLE.
//  Threads spawned this epoch are never evaluated twice: the walk uses snap, not the live mask.
//  Latency with ev_ack tied high: sample_vld at t, N live threads -> done at t+3+2N.
//   - busy high t+1..t+3+2N.
//  ev_result pulses: registered, asserted the cycle after ack; 00 gives no pulse.
//   - succ_cnt/fail_cnt saturate at 2^CNT_W-1; lazy is not counted.
//  overrun: sample_vld while not IDLE pulses overrun next cycle; the epoch in progress is unaffected.
//  active_cnt = popcount(valid), registered and updated with each valid write.
//  Evaluator stall: ev_req held indefinitely; no timeout.
// TESTING
//  1. Reset, ack tied high, next_active=1 res=00, pulse sample_vld x1 -> ev_req once (slot0, START_STATE); done at t+3; active_cnt=1.
//  2. 3 live threads, sample_vld -> slots 0,1,2 issued in order, then spawn into slot3; done at t+9; active_cnt=4.
//  3. Pool full (4 live, all stay active) -> 4 issues, spawn_drop=1, active_cnt stays 4.
//  4. Slot1 returns next_active=0 res=10 -> fail pulse, fail_cnt+1, spawn reuses slot1.
//  5. ev_ack delayed 5 cycles -> ev_req/ev_slot/ev_state stable; sample_vld meanwhile -> overrun, epoch unchanged.
//  6. grst asserted during ISSUE -> ev_req, busy, active_cnt = 0 immediately; next sample spawns into slot0.

Source files
------------

// File: rtl/sva_thread_scheduler.sv
// Thread scheduler for the SVA checker: walks every live assertion thread once per sample
// epoch through a shared evaluator (req/ack), then spawns one fresh thread.
module sva_thread_scheduler #(
  parameter int                 MAX_THREADS = 4,
  parameter int                 STATE_W     = 4,
  parameter logic [STATE_W-1:0] START_STATE = '0,
  parameter int                 EPOCH_W     = 8,
  parameter int                 CNT_W       = 16,
  localparam int                SLOT_W      = $clog2(MAX_THREADS)
) (
  input  logic               gclk,
  input  logic               grst,
  input  logic               sample_vld,
  output logic               busy,
  output logic               ev_req,
  output logic [SLOT_W-1:0]  ev_slot,
  output logic [STATE_W-1:0] ev_state,
  output logic [EPOCH_W-1:0] ev_start,
  input  logic               ev_ack,
  input  logic [STATE_W-1:0] ev_next_state,
  input  logic               ev_next_active,
  input  logic [1:0]         ev_result,
  output logic               succ,
  output logic               fail,
  output logic               lazy,
  output logic               done,
  output logic               overrun,
  output logic               spawn_drop,
  output logic [SLOT_W:0]    active_cnt,
  output logic [CNT_W-1:0]   succ_cnt,
  output logic [CNT_W-1:0]   fail_cnt
);

  typedef enum logic [2:0] {IDLE, SCAN, ISSUE, SPAWN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [MAX_THREADS-1:0]   valid_q, valid_d, snap_q;
  logic [STATE_W-1:0]       slot_state_q [MAX_THREADS];
  logic [EPOCH_W-1:0]       slot_start_q [MAX_THREADS];
  logic [SLOT_W:0]          cur_q;
  logic [SLOT_W-1:0]        iss_q;
  logic [EPOCH_W-1:0]       epoch_q;
  logic                     scan_found, free_found, ack_take;
  logic [SLOT_W-1:0]        scan_idx, free_idx, wr_idx;

  function automatic logic [SLOT_W:0] popcnt(input logic [MAX_THREADS-1:0] m);
    logic [SLOT_W:0] c;
    c = '0;
    for (int i = 0; i < MAX_THREADS; i++) c = c + (SLOT_W+1)'(m[i]);
    return c;
  endfunction

  // Walk follows the epoch snapshot; spawn uses the live mask so freed slots are reused.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = MAX_THREADS-1; i >= 0; i--) begin
      if (snap_q[i] && ((SLOT_W+1)'(i) >= cur_q)) begin
        scan_found = 1'b1;
        scan_idx   = SLOT_W'(i);
      end
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ev_req   = 1'b0;
    ev_slot  = '0;
    ev_state = '0;
    ev_start = '0;
    case (state_q)
      IDLE:  if (sample_vld) state_d = SCAN;
      SCAN:  state_d = scan_found ? ISSUE : SPAWN;
      ISSUE: begin
        ev_req   = 1'b1;
        ev_slot  = iss_q;
        ev_state = slot_state_q[iss_q];
        ev_start = slot_start_q[iss_q];
        if (ev_ack) state_d = SCAN;
      end
      SPAWN: begin
        if (!free_found) begin
          state_d = DONE;
        end else begin
          ev_req   = 1'b1;
          ev_slot  = free_idx;
          ev_state = START_STATE;
          ev_start = epoch_q;
          if (ev_ack) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ack_take = ev_req && ev_ack;
  assign wr_idx   = (state_q == ISSUE) ? iss_q : free_idx;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

  always_comb begin
    valid_d = valid_q;
    if (ack_take) valid_d[wr_idx] = ev_next_active;
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      snap_q     <= '0;
      cur_q      <= '0;
      iss_q      <= '0;
      epoch_q    <= '0;
      succ       <= 1'b0;
      fail       <= 1'b0;
      lazy       <= 1'b0;
      overrun    <= 1'b0;
      spawn_drop <= 1'b0;
      active_cnt <= '0;
      succ_cnt   <= '0;
      fail_cnt   <= '0;
      for (int i = 0; i < MAX_THREADS; i++) begin
        slot_state_q[i] <= '0;
        slot_start_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      active_cnt <= popcnt(valid_d);
      overrun    <= sample_vld && (state_q != IDLE);
      spawn_drop <= (state_q == SPAWN) && !free_found;
      succ       <= ack_take && (ev_result == 2'b01);
      fail       <= ack_take && (ev_result == 2'b10);
      lazy       <= ack_take && (ev_result == 2'b11);
      if (state_q == IDLE && sample_vld) begin
        snap_q  <= valid_q;
        cur_q   <= '0;
        epoch_q <= epoch_q + 1'b1;
      end
      if (state_q == SCAN) iss_q <= scan_idx;
      if (state_q == ISSUE && ev_ack) cur_q <= {1'b0, iss_q} + (SLOT_W+1)'(1);
      if (ack_take) begin
        slot_state_q[wr_idx] <= ev_next_state;
        if (state_q == SPAWN) slot_start_q[wr_idx] <= epoch_q;
        if (ev_result == 2'b01 && succ_cnt != '1) succ_cnt <= succ_cnt + 1'b1;
        if (ev_result == 2'b10 && fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sva_thread_scheduler.sv
// Bench for sva_thread_scheduler: directed epochs plus randomized evaluator responses,
// checked against a slot-pool model of the scheduling rules.
module tb_sva_thread_scheduler;

  logic        gclk = 1'b0;
  logic        grst;
  logic        sample_vld;
  logic        busy, ev_req, ev_ack, ev_next_active;
  logic [1:0]  ev_slot;
  logic [3:0]  ev_state, ev_next_state;
  logic [7:0]  ev_start;
  logic [1:0]  ev_result;
  logic        succ, fail, lazy, done, overrun, spawn_drop;
  logic [2:0]  active_cnt;
  logic [15:0] succ_cnt, fail_cnt;

  int checks = 0;
  int errors = 0;

  // Model of the thread pool
  bit          m_valid [4];
  int          m_state [4];
  int          m_start [4];
  int          m_epoch;
  int          m_succ, m_fail;

  // Directed evaluator responses per slot
  bit          d_act [4];
  int          d_res [4];

  sva_thread_scheduler dut (
    .gclk(gclk), .grst(grst), .sample_vld(sample_vld), .busy(busy),
    .ev_req(ev_req), .ev_slot(ev_slot), .ev_state(ev_state), .ev_start(ev_start),
    .ev_ack(ev_ack), .ev_next_state(ev_next_state), .ev_next_active(ev_next_active),
    .ev_result(ev_result), .succ(succ), .fail(fail), .lazy(lazy), .done(done),
    .overrun(overrun), .spawn_drop(spawn_drop), .active_cnt(active_cnt),
    .succ_cnt(succ_cnt), .fail_cnt(fail_cnt)
  );

  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_live();
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(m_valid[i]);
    return n;
  endfunction

  function automatic int lowest_free();
    for (int i = 0; i < 4; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  // One sample epoch; every request is acked after 'delay' waiting cycles.
  task automatic run_epoch(input string name, input int delay, input bit directed, input int ovr_cyc);
    int walk[$];
    int idx = 0, cyc, waitc = 0, served = 0, n_live, slot, res, ns;
    bit act, pend = 0, ovr_pend = 0, seen_done = 0, spawned = 0, exp_drop;
    int pend_res = 0, spawn_req = 0;
    for (int i = 0; i < 4; i++) if (m_valid[i]) walk.push_back(i);
    n_live = walk.size();
    m_epoch = (m_epoch + 1) % 256;
    sample_vld = 1'b1;
    @(negedge gclk);
    sample_vld = 1'b0;
    cyc = 1;
    while (cyc < 200) begin
      if (ovr_pend) begin
        sample_vld = 1'b0;
        ovr_pend   = 0;
        chk({name, ".overrun"}, overrun, 1);
      end
      if (pend) begin
        chk({name, ".succ"}, succ, pend_res == 1);
        chk({name, ".fail"}, fail, pend_res == 2);
        chk({name, ".lazy"}, lazy, pend_res == 3);
        pend = 0;
      end
      if (done) begin
        seen_done = 1;
        break;
      end
      chk({name, ".busy"}, busy, 1);
      if (ovr_cyc == cyc) begin
        sample_vld = 1'b1;
        ovr_pend   = 1;
      end
      ev_ack = 1'b0;
      if (ev_req) begin
        if (idx < walk.size()) begin
          slot = walk[idx];
          chk({name, ".ev_slot"},  ev_slot,  slot);
          chk({name, ".ev_state"}, ev_state, m_state[slot]);
          chk({name, ".ev_start"}, ev_start, m_start[slot]);
        end else begin
          slot = lowest_free();
          spawned = 1;
          chk({name, ".spawn_slot"},  ev_slot,  slot);
          chk({name, ".spawn_state"}, ev_state, 0);
          chk({name, ".spawn_start"}, ev_start, m_epoch);
        end
        if (slot >= 0 && waitc >= delay) begin
          if (directed) begin
            act = d_act[slot];
            res = d_res[slot];
            ns  = (slot + 5) % 16;
          end else begin
            act = 1'($urandom_range(0, 3) != 0);
            res = int'($urandom_range(0, 3));
            ns  = int'($urandom_range(0, 15));
          end
          ev_ack = 1'b1;
          ev_next_active = act;
          ev_next_state  = 4'(ns);
          ev_result      = 2'(res);
          m_valid[slot] = act;
          m_state[slot] = ns;
          if (idx >= walk.size()) m_start[slot] = m_epoch;
          if (res == 1 && m_succ < 65535) m_succ++;
          if (res == 2 && m_fail < 65535) m_fail++;
          pend = 1;
          pend_res = res;
          served++;
          idx++;
          waitc = 0;
        end else begin
          waitc++;
        end
      end
      if (spawned) spawn_req = 1;
      @(negedge gclk);
      cyc++;
    end
    ev_ack = 1'b0;
    sample_vld = 1'b0;
    chk({name, ".done_seen"}, seen_done, 1);
    exp_drop = (n_live == 4) && (m_valid[0] && m_valid[1] && m_valid[2] && m_valid[3]) && (spawn_req == 0);
    chk({name, ".latency"}, cyc, 3 + 2 * n_live + delay * (n_live + (exp_drop ? 0 : 1)));
    chk({name, ".requests"}, served, n_live + (exp_drop ? 0 : 1));
    chk({name, ".spawn_drop"}, spawn_drop, exp_drop);
    chk({name, ".active_cnt"}, active_cnt, model_live());
    chk({name, ".succ_cnt"}, succ_cnt, m_succ);
    chk({name, ".fail_cnt"}, fail_cnt, m_fail);
    @(negedge gclk);
    chk({name, ".idle"}, busy, 0);
  endtask

  task automatic applyReset();
    grst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 0;
      m_state[i] = 0;
      m_start[i] = 0;
    end
    m_epoch = 0;
    m_succ  = 0;
    m_fail  = 0;
    @(negedge gclk);
    @(negedge gclk);
    grst = 1'b0;
    @(negedge gclk);
  endtask

  task automatic set_dir(input bit all_act, input int all_res);
    for (int i = 0; i < 4; i++) begin
      d_act[i] = all_act;
      d_res[i] = all_res;
    end
  endtask

  initial begin
    int cycles;
    sample_vld = 1'b0;
    ev_ack = 1'b0;
    ev_next_active = 1'b0;
    ev_next_state = '0;
    ev_result = '0;
    applyReset();
    chk("reset.busy", busy, 0);
    chk("reset.ev_req", ev_req, 0);
    chk("reset.active_cnt", active_cnt, 0);
    chk("reset.succ_cnt", succ_cnt, 0);
    chk("reset.fail_cnt", fail_cnt, 0);
    chk("reset.done", done, 0);

    // First epoch spawns slot 0, then three more build up to a full pool
    set_dir(1, 0);
    run_epoch("spawn1", 0, 1, 0);
    run_epoch("spawn2", 0, 1, 0);
    run_epoch("spawn3", 0, 1, 0);
    run_epoch("three_live", 0, 1, 0);
    run_epoch("pool_full", 0, 1, 0);

    // Slot 1 dies with a fail result and is reused by the spawn
    d_act[1] = 0;
    d_res[1] = 2;
    run_epoch("slot1_fail", 0, 1, 0);

    // Stalled evaluator with an overlapping sample
    set_dir(1, 1);
    run_epoch("stall", 5, 1, 3);
    d_res[2] = 3;
    run_epoch("lazy", 0, 1, 0);

    // Reset while a request is outstanding
    sample_vld = 1'b1;
    @(negedge gclk);
    sample_vld = 1'b0;
    cycles = 0;
    while (!ev_req && cycles < 20) begin
      @(negedge gclk);
      cycles++;
    end
    chk("rst_mid.req_seen", ev_req, 1);
    #1 grst = 1'b1;
    #1;
    chk("rst_mid.ev_req", ev_req, 0);
    chk("rst_mid.busy", busy, 0);
    chk("rst_mid.active_cnt", active_cnt, 0);
    applyReset();
    set_dir(1, 0);
    run_epoch("after_rst", 0, 1, 0);

    // Randomized evaluator responses and ack delays
    for (int e = 0; e < 40; e++) begin
      run_epoch("random", int'($urandom_range(0, 2)), 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
